// File: rtl/nios2_pkg.sv
// Shared constants and types for the nios2 fetch front end.
package nios2_pkg;

  localparam int          XLEN     = 32;
  localparam logic [31:0] PC_INC   = 32'd4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  // Major opcodes (instr[5:0]) the front end may want to recognise early.
  localparam logic [5:0] OP_RTYPE = 6'b111010;
  localparam logic [5:0] OP_LDW   = 6'b010111;
  localparam logic [5:0] OP_STW   = 6'b010101;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_REDIR = 2'd2
  } fetch_state_t;

  // One prefetch FIFO slot: instruction word and its "pc after fetch".
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/nios2_fetch_fifo.sv
// Small circular prefetch buffer of {instr, pc}; flush beats push.
module nios2_fetch_fifo import nios2_pkg::*; #(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            push,
  input  fetch_entry_t    push_data,
  input  logic            pop,
  output logic [CW-1:0]   count,
  output fetch_entry_t    head
);

  localparam int PW = $clog2(DEPTH);

  fetch_entry_t    mem [DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic            pop_ok;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  assign pop_ok = pop && (count != '0);
  assign head   = (count != '0) ? mem[rd_ptr] : '0;

  // Storage: written on push only, never reset.
  always_ff @(posedge clk) begin
    if (!rst && !flush && push) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy; flush empties the buffer regardless of push/pop.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= nxt(wr_ptr);
      if (pop_ok) rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(push) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/nios2_fetch.sv
// Instruction fetch: owns the PC, reads a 1-cycle-latency ROM, buffers
// words in a prefetch FIFO and hands them to decode on valid/ready.
module nios2_fetch import nios2_pkg::*; #(
  parameter logic [31:0] RESET_PC = nios2_pkg::RESET_PC,
  parameter int          DEPTH    = 2,
  parameter logic [31:0] PC_INC   = nios2_pkg::PC_INC
) (
  input  logic        clk18,
  input  logic        rst18,
  output logic        imem_req18,
  output logic [31:0] imem_addr18,
  input  logic [31:0] imem_rdata18,
  input  logic        redirect18,
  input  logic [31:0] redirect_pc18,
  output logic        instr_valid18,
  input  logic        instr_ready18,
  output logic [31:0] instr18,
  output logic [31:0] instr_pc18
);

  localparam int CW = $clog2(DEPTH+1);

  fetch_state_t   state;
  logic [31:0]    pc;
  logic           inflight;
  logic [CW-1:0]  count;
  fetch_entry_t   head, push_data;
  logic           pop, push, issue;
  logic [CW+1:0]  occ;

  assign instr_valid18 = !rst18 && (count != '0);
  assign instr18       = instr_valid18 ? head.instr : '0;
  assign instr_pc18    = instr_valid18 ? head.pc    : '0;
  assign pop           = instr_valid18 && instr_ready18;

  // Occupancy the FIFO will have once this cycle's pop and in-flight word land.
  assign occ   = (CW+2)'(count) + (CW+2)'(inflight) - (CW+2)'(pop);
  // No read in a redirect cycle: its data would be discarded anyway.
  assign issue = !rst18 && !redirect18 && (state == S_RUN) && (occ < (CW+2)'(DEPTH));

  assign imem_req18  = issue;
  assign imem_addr18 = rst18 ? RESET_PC : pc;

  // pc already advanced past the word now returning, which is exactly the
  // "pc after fetch" value decode wants for it.
  assign push           = inflight && !redirect18;
  assign push_data.instr = imem_rdata18;
  assign push_data.pc    = pc;

  // PC / in-flight tracking and fetch FSM.
  always_ff @(posedge clk18) begin
    if (rst18) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      inflight <= 1'b0;
    end else if (redirect18) begin
      state    <= S_REDIR;
      pc       <= redirect_pc18 & 32'hFFFF_FFFC;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) pc <= pc + PC_INC;
      case (state)
        S_IDLE:  state <= S_RUN;
        S_REDIR: state <= S_RUN;
        S_RUN:   state <= S_RUN;
        default: state <= S_IDLE;
      endcase
    end
  end

  nios2_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk18),
    .rst       (rst18),
    .flush     (redirect18),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .count     (count),
    .head      (head)
  );

endmodule

// File: tb/tb_nios2_fetch.sv
// Directed bench for nios2_fetch: free-run, backpressure, redirects,
// PC wrap (second instance) and reset mid-operation.
module tb_nios2_fetch;

  logic        clk18 = 1'b0;
  logic        rst18, redirect18, instr_ready18;
  logic [31:0] redirect_pc18;

  logic        imem_req18, instr_valid18;
  logic [31:0] imem_addr18, imem_rdata18, instr18, instr_pc18;

  logic        w_req, w_valid;
  logic [31:0] w_addr, w_rdata, w_instr, w_ipc;

  int n_pass  = 0;
  int n_total = 0;
  int pops    = 0;

  always #5 clk18 = ~clk18;

  nios2_fetch dut (
    .clk18(clk18), .rst18(rst18),
    .imem_req18(imem_req18), .imem_addr18(imem_addr18), .imem_rdata18(imem_rdata18),
    .redirect18(redirect18), .redirect_pc18(redirect_pc18),
    .instr_valid18(instr_valid18), .instr_ready18(instr_ready18),
    .instr18(instr18), .instr_pc18(instr_pc18)
  );

  nios2_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk18(clk18), .rst18(rst18),
    .imem_req18(w_req), .imem_addr18(w_addr), .imem_rdata18(w_rdata),
    .redirect18(redirect18), .redirect_pc18(redirect_pc18),
    .instr_valid18(w_valid), .instr_ready18(instr_ready18),
    .instr18(w_instr), .instr_pc18(w_ipc)
  );

  // ROM contents: word at byte address a is 0xA0 + a/4.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'hA0 + (a >> 2);
  endfunction

  always @(posedge clk18) begin
    if (imem_req18) imem_rdata18 <= rom_word(imem_addr18);
    if (w_req)      w_rdata      <= rom_word(w_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, {31'd0, obs}, {31'd0, exp});
  endtask

  task automatic tick;
    @(posedge clk18); #1;
  endtask

  // Two reset edges, check reset outputs, release; returns in the idle cycle.
  task automatic do_reset;
    rst18 = 1'b1; redirect18 = 1'b0; redirect_pc18 = '0; instr_ready18 = 1'b1;
    tick; tick;
    chk1("rst_req",   imem_req18, 1'b0);
    chk1("rst_valid", instr_valid18, 1'b0);
    chk ("rst_instr", instr18, 32'h0);
    chk ("rst_ipc",   instr_pc18, 32'h0);
    chk ("rst_addr",  imem_addr18, 32'h0);
    chk ("rst_waddr", w_addr, 32'hFFFF_FFF8);
    rst18 = 1'b0; #1;
    chk1("idle_req", imem_req18, 1'b0);
  endtask

  initial begin
    // ---- 1: free-run, plus PC wrap on the second instance ----
    do_reset;
    tick; // E1
    chk1("t1_req0", imem_req18, 1'b1);
    chk ("t1_addr0", imem_addr18, 32'd0);
    chk ("t5_addr0", w_addr, 32'hFFFF_FFF8);
    chk1("t1_nv1", instr_valid18, 1'b0);
    tick; // E2
    chk ("t1_addr1", imem_addr18, 32'd4);
    chk ("t5_addr1", w_addr, 32'hFFFF_FFFC);
    chk1("t1_nv2", instr_valid18, 1'b0);
    tick; // E3: first valid
    chk1("t1_v", instr_valid18, 1'b1);
    chk ("t1_i0", instr18, 32'hA0);
    chk ("t1_p0", instr_pc18, 32'd4);
    chk ("t1_addr2", imem_addr18, 32'd8);
    chk ("t5_addr2", w_addr, 32'h0);
    chk ("t5_i0", w_instr, 32'h4000_009E);
    chk ("t5_p0", w_ipc, 32'hFFFF_FFFC);
    tick;
    chk ("t1_i1", instr18, 32'hA1);
    chk ("t1_p1", instr_pc18, 32'd8);
    chk ("t1_addr3", imem_addr18, 32'd12);
    chk ("t5_addr3", w_addr, 32'd4);
    chk ("t5_i1", w_instr, 32'h4000_009F);
    chk ("t5_p1", w_ipc, 32'h0);
    tick;
    chk ("t1_i2", instr18, 32'hA2);
    chk ("t5_i2", w_instr, 32'hA0);
    chk ("t5_p2", w_ipc, 32'd4);
    tick;
    chk ("t1_i3", instr18, 32'hA3);
    chk ("t1_p3", instr_pc18, 32'd16);

    // ---- 2: backpressure ----
    do_reset;
    tick; tick; tick; // E3
    chk ("t2_first", instr18, 32'hA0);
    instr_ready18 = 1'b0; #1;
    chk1("t2_req_hold", imem_req18, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick;
      chk1("t2_valid", instr_valid18, 1'b1);
      chk ("t2_instr", instr18, 32'hA0);
      chk1("t2_req_full", imem_req18, 1'b0);
      chk ("t2_count", 32'(dut.count), 32'd2);
    end
    instr_ready18 = 1'b1; #1;
    chk ("t2_o0", instr18, 32'hA0);
    chk1("t2_rreq", imem_req18, 1'b1);
    chk ("t2_raddr", imem_addr18, 32'd8);
    tick;
    chk ("t2_o1", instr18, 32'hA1);
    chk ("t2_p1", instr_pc18, 32'd8);
    tick;
    chk ("t2_o2", instr18, 32'hA2);
    chk ("t2_p2", instr_pc18, 32'd12);
    tick;
    chk ("t2_o3", instr18, 32'hA3);

    // ---- 3: redirect while fetching at 40 ----
    do_reset;
    for (int i = 0; i < 11; i++) tick;
    chk1("t3_req", imem_req18, 1'b1);
    chk ("t3_addr40", imem_addr18, 32'd40);
    chk ("t3_head", instr18, 32'hA8);
    redirect18 = 1'b1; redirect_pc18 = 32'h0000_000E; #1;
    chk1("t3_req_redir", imem_req18, 1'b0);
    tick;
    redirect18 = 1'b0; #1;
    chk1("t3_flush_v", instr_valid18, 1'b0);
    chk1("t3_bubble", imem_req18, 1'b0);
    tick;
    chk1("t3_req_tgt", imem_req18, 1'b1);
    chk ("t3_addr_tgt", imem_addr18, 32'd12);
    chk1("t3_nv1", instr_valid18, 1'b0);
    tick;
    chk ("t3_addr_nxt", imem_addr18, 32'd16);
    chk1("t3_nv2", instr_valid18, 1'b0);
    tick;
    chk1("t3_v", instr_valid18, 1'b1);
    chk ("t3_instr", instr18, 32'hA3);
    chk ("t3_ipc", instr_pc18, 32'd16);

    // ---- 4: redirect with pop, then back-to-back redirects 8 -> 20 ----
    redirect18 = 1'b1; redirect_pc18 = 32'd8; #1;
    chk ("t4_popped", instr18, 32'hA3);
    pops += int'(instr_valid18 && instr_ready18);
    tick;
    redirect_pc18 = 32'd20; #1;
    chk1("t4_nv0", instr_valid18, 1'b0);
    chk1("t4_nreq0", imem_req18, 1'b0);
    pops += int'(instr_valid18 && instr_ready18);
    tick;
    redirect18 = 1'b0; #1;
    chk1("t4_nv1", instr_valid18, 1'b0);
    chk1("t4_bubble", imem_req18, 1'b0);
    chk ("t4_pc20", imem_addr18, 32'd20);
    pops += int'(instr_valid18 && instr_ready18);
    tick;
    chk1("t4_req", imem_req18, 1'b1);
    chk ("t4_addr20", imem_addr18, 32'd20);
    pops += int'(instr_valid18 && instr_ready18);
    tick;
    chk ("t4_addr24", imem_addr18, 32'd24);
    pops += int'(instr_valid18 && instr_ready18);
    tick;
    chk ("t4_instr", instr18, 32'hA5);
    chk ("t4_ipc", instr_pc18, 32'd24);
    pops += int'(instr_valid18 && instr_ready18);
    chk ("t4_pops", 32'(pops), 32'd2);

    // ---- 6: reset with full FIFO and redirect pending ----
    instr_ready18 = 1'b0; #1;
    tick;
    chk ("t6_full", 32'(dut.count), 32'd2);
    chk ("t6_head", instr18, 32'hA5);
    rst18 = 1'b1; redirect18 = 1'b1; redirect_pc18 = 32'h100; #1;
    chk1("t6_rst_req", imem_req18, 1'b0);
    chk1("t6_rst_v", instr_valid18, 1'b0);
    chk ("t6_rst_instr", instr18, 32'h0);
    tick;
    rst18 = 1'b0; redirect18 = 1'b0; instr_ready18 = 1'b1; #1;
    chk1("t6_v", instr_valid18, 1'b0);
    chk1("t6_req", imem_req18, 1'b0);
    chk ("t6_pc", imem_addr18, 32'h0);
    tick;
    chk1("t6_req1", imem_req18, 1'b1);
    chk ("t6_addr", imem_addr18, 32'h0);
    tick; tick;
    chk ("t6_instr", instr18, 32'hA0);
    chk ("t6_ipc", instr_pc18, 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
